systolic_skew_feeder: RTL and testbench

Upstream feeder for the 3x3 systolic PE array. It accepts one activation matrix as N row vectors over a valid/ready handshake and buffers them. It then drives the array's packed left-edge input bus with diagonally skewed data: lane i is delayed i cycles. After the skew, it drains the array with zeros while holding the array enable high, then pulses `done`.

---
 rtl/systolic_skew_feeder.sv | 162 ++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Skewed left-edge feeder for the NxN systolic array: buffer, stream, drain.
// Optional ping-pong buffering is enabled by defining SKEW_DBUF_EN.
module systolic_skew_feeder #(
  parameter int N      = 3,
  parameter int DWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DWIDTH-1:0]   in_data,
  input  logic                  hold,
  output logic [N*DWIDTH-1:0]   out_data,
  output logic                  en_o,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DRAIN
  } state_t;

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST_B = CW'(2 * N - 2);
  localparam logic [IW-1:0] LAST_L = IW'(N - 1);

`ifdef SKEW_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  state_t            state;
  logic [IW-1:0]     ld_cnt;
  logic [IW-1:0]     dcnt;
  logic [CW-1:0]     beat;
  logic              rd_sel;
  logic              wr_sel;
  logic              acc;
  logic              last_ld;
  logic [N*DWIDTH-1:0] mem [NB][N];

`ifdef SKEW_DBUF_EN
  logic              sh_full;
  assign in_ready = (state == LOAD) | ~sh_full;
  assign wr_sel   = (state == LOAD) ? rd_sel : ~rd_sel;
`else
  assign rd_sel   = 1'b0;
  assign in_ready = (state == LOAD);
  assign wr_sel   = rd_sel;
`endif

  assign acc     = in_valid & in_ready;
  assign last_ld = (ld_cnt == LAST_L);

  // Lane i shows vector (b-i), zero outside the matrix diagonal band.
  function automatic logic [N*DWIDTH-1:0] skew(
    input logic          s,
    input logic [CW-1:0] b
  );
    logic [N*DWIDTH-1:0] r;
    logic [N*DWIDTH-1:0] row;
    int d;
    r = '0;
    for (int i = 0; i < N; i++) begin
      d = int'(b) - i;
      if (d >= 0 && d < N) begin
        row = mem[s][IW'(d)];
        r[i*DWIDTH +: DWIDTH] = row[i*DWIDTH +: DWIDTH];
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (acc) mem[wr_sel][ld_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD;
      ld_cnt   <= '0;
      beat     <= '0;
      dcnt     <= '0;
      out_data <= '0;
      en_o     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SKEW_DBUF_EN
      rd_sel   <= 1'b0;
      sh_full  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (acc) ld_cnt <= last_ld ? '0 : ld_cnt + 1'b1;
`ifdef SKEW_DBUF_EN
      if (acc && last_ld && state != LOAD) sh_full <= 1'b1;
`endif
      unique case (state)
        LOAD: begin
          en_o <= 1'b0;
          if (acc && last_ld) begin
            state    <= STREAM;
            beat     <= '0;
            out_data <= skew(rd_sel, '0);
            en_o     <= 1'b1;
            busy     <= 1'b1;
          end
        end
        STREAM: begin
          if (hold) begin
            en_o <= 1'b0;
          end else begin
            en_o <= 1'b1;
            if (beat == LAST_B) begin
              state    <= DRAIN;
              dcnt     <= '0;
              out_data <= '0;
            end else begin
              beat     <= beat + 1'b1;
              out_data <= skew(rd_sel, beat + 1'b1);
            end
          end
        end
        DRAIN: begin
          if (hold) begin
            en_o <= 1'b0;
          end else if (dcnt == LAST_L) begin
            done <= 1'b1;
`ifdef SKEW_DBUF_EN
            rd_sel <= ~rd_sel;
            if (sh_full || (acc && last_ld)) begin
              // Shadow already full: restart straight away, no bubble.
              sh_full  <= 1'b0;
              state    <= STREAM;
              beat     <= '0;
              out_data <= skew(~rd_sel, '0);
              en_o     <= 1'b1;
            end else begin
              state <= LOAD;
              en_o  <= 1'b0;
              busy  <= 1'b0;
            end
`else
            state <= LOAD;
            en_o  <= 1'b0;
            busy  <= 1'b0;
`endif
          end else begin
            dcnt <= dcnt + 1'b1;
            en_o <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder against a matrix-level skew model.
module tb_systolic_skew_feeder;

  localparam int N  = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic            hold;
  logic [N*DW-1:0] out_data;
  logic            en_o;
  logic            busy;
  logic            done;

  systolic_skew_feeder #(.N(N), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .hold(hold), .out_data(out_data),
    .en_o(en_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int run = 0;
  int max_run = 0;
  int dones = 0;
  logic [N*DW-1:0] exp_q[$];
  logic [N*DW-1:0] prev_out = '0;
  logic [DW-1:0]   cur_m [N][N];

  // Reference: lane i at step b carries M[b-i][i]; then N all-zero drain steps.
  task automatic push_exp();
    logic [N*DW-1:0] vec;
    for (int b = 0; b < 2*N-1; b++) begin
      vec = '0;
      for (int i = 0; i < N; i++)
        if (b - i >= 0 && b - i < N) vec[i*DW +: DW] = cur_m[b-i][i];
      exp_q.push_back(vec);
    end
    for (int k = 0; k < N; k++) exp_q.push_back('0);
  endtask

  task automatic chk(input string name, input logic [N*DW-1:0] act,
                     input logic [N*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic load_matrix(input int gap);
    logic [N*DW-1:0] row;
    logic rdy;
    bit ok;
    for (int v = 0; v < N; v++) begin
      for (int i = 0; i < N; i++) row[i*DW +: DW] = cur_m[v][i];
      in_data  = row;
      in_valid = 1'b1;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        ok = rdy;
      end
      in_valid = 1'b0;
      in_data  = N*DW'($urandom);
      if (!ok) begin
        errors++;
        checks++;
        $display("FAIL load_timeout: vector %0d not accepted", v);
      end
      if (v < N-1) begin
`ifndef SKEW_DBUF_EN
        chk("busy_while_loading", {{(N*DW-1){1'b0}}, busy}, '0);
`endif
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    push_exp();
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: done=0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_matrix();
    for (int v = 0; v < N; v++)
      for (int i = 0; i < N; i++) cur_m[v][i] = DW'($urandom);
  endtask

  // Monitor: pops one expected vector per enabled beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        en_cnt = 0;
        run = 0;
      end else begin
        if (done) begin
          dones++;
          checks++;
          if (en_cnt != 3*N-1) begin
            errors++;
            $display("FAIL en_count: got %0d expected %0d", en_cnt, 3*N-1);
          end
          en_cnt = 0;
`ifndef SKEW_DBUF_EN
          chk("done_cycle_flags", {en_o, busy, in_ready}, 3'b001);
          checks++;
          if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d queued expected 0", exp_q.size());
          end
`endif
        end
        if (en_o) begin
          en_cnt++;
          run++;
          if (run > max_run) max_run = run;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_en: got en_o=1 expected no beat");
          end else begin
            chk("out_data", out_data, exp_q.pop_front());
          end
        end else begin
          run = 0;
          if (busy) chk("hold_out_data", out_data, prev_out);
        end
      end
      prev_out = out_data;
    end
  end

  bit stop_hold;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", out_data, '0);
    chk("rst_flags", {en_o, busy, done}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {{(N*DW-1){1'b0}}, in_ready}, 1);

    for (int v = 0; v < N; v++)
      for (int i = 0; i < N; i++) cur_m[v][i] = DW'(v*N + i + 1);
    load_matrix(0);
    wait_done();

    load_matrix(0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    hold = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    wait_done();

    rand_matrix();
    load_matrix(1);
    wait_done();

`ifndef SKEW_DBUF_EN
    rand_matrix();
    load_matrix(0);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = N*DW'($urandom);
      @(posedge clk);
      #1;
      chk("in_ready_stream", {{(N*DW-1){1'b0}}, in_ready}, '0);
    end
    in_valid = 1'b0;
    wait_done();
`endif

    for (int v = 0; v < N; v++)
      for (int i = 0; i < N; i++) cur_m[v][i] = DW'($urandom);
    load_matrix(0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out", out_data, '0);
    chk("async_rst_flags", {en_o, busy, done}, '0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {{(N*DW-1){1'b0}}, in_ready}, 1);
    for (int v = 0; v < N; v++)
      for (int i = 0; i < N; i++) cur_m[v][i] = 8'd9;
    load_matrix(0);
    wait_done();

    stop_hold = 0;
    fork
      begin
        for (int m = 0; m < 6; m++) begin
          rand_matrix();
          load_matrix(int'($urandom_range(0, 2)));
          wait_done();
        end
        stop_hold = 1;
      end
      begin
        while (!stop_hold) begin
          @(posedge clk);
          #1;
          hold = ($urandom_range(0, 3) == 0);
        end
        hold = 1'b0;
      end
    join

`ifdef SKEW_DBUF_EN
    max_run = 0;
    dones = 0;
    rand_matrix();
    load_matrix(0);
    rand_matrix();
    load_matrix(0);
    wait_done();
    wait_done();
    checks++;
    if (max_run != 2*(3*N-1) || dones != 2) begin
      errors++;
      $display("FAIL dbuf_run: got run=%0d dones=%0d expected %0d and 2",
               max_run, dones, 2*(3*N-1));
    end
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
